// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between instruction fetch and the load/store path.
// One transfer at a time: grant, hold the port until mrdy or timeout, then a single-cycle ack.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int FAIR    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ireq,
  input  logic [ADDR_W-1:0]   iaddr,
  output logic                iack,
  output logic [DATA_W-1:0]   irdata,
  input  logic                dreq,
  input  logic                dwe,
  input  logic [ADDR_W-1:0]   daddr,
  input  logic [DATA_W-1:0]   dwdata,
  input  logic [DATA_W/8-1:0] dbe,
  output logic                dack,
  output logic [DATA_W-1:0]   drdata,
  output logic                err,
  output logic                mreq,
  output logic                mwe,
  output logic [ADDR_W-1:0]   maddr,
  output logic [DATA_W-1:0]   mwdata,
  output logic [DATA_W/8-1:0] mbe,
  input  logic [DATA_W-1:0]   mrdata,
  input  logic                mrdy,
  output logic                stall
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, ACK} state_t;

  state_t              state_reg, state_next;
  logic                mreq_reg, mreq_next;
  logic                mwe_reg, mwe_next;
  logic [ADDR_W-1:0]   maddr_reg, maddr_next;
  logic [DATA_W-1:0]   mwdata_reg, mwdata_next;
  logic [BE_W-1:0]     mbe_reg, mbe_next;
  logic                iack_reg, iack_next;
  logic                dack_reg, dack_next;
  logic                err_reg, err_next;
  logic [DATA_W-1:0]   irdata_reg, irdata_next;
  logic [DATA_W-1:0]   drdata_reg, drdata_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                last_data_reg, last_data_next;

  logic                tie_to_data;
  logic                grant_data;
  logic                busy;
  logic                timeout_hit;
  logic [BE_W-1:0]     be_sel;

  // On a tie, FAIR=1 alternates away from whoever was served last.
  assign tie_to_data = (FAIR == 0) ? 1'b1 : ~last_data_reg;
  assign grant_data  = dreq & (~ireq | tie_to_data);
  assign busy        = (state_reg == IBUSY) || (state_reg == DBUSY);

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
    end
  endgenerate

  // Fetches always read the whole word.
  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_be
      assign be_sel[gi] = grant_data ? dbe[gi] : 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mreq_reg      <= 1'b0;
      mwe_reg       <= 1'b0;
      maddr_reg     <= '0;
      mwdata_reg    <= '0;
      mbe_reg       <= '0;
      iack_reg      <= 1'b0;
      dack_reg      <= 1'b0;
      err_reg       <= 1'b0;
      irdata_reg    <= '0;
      drdata_reg    <= '0;
      cnt_reg       <= '0;
      last_data_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mreq_reg      <= mreq_next;
      mwe_reg       <= mwe_next;
      maddr_reg     <= maddr_next;
      mwdata_reg    <= mwdata_next;
      mbe_reg       <= mbe_next;
      iack_reg      <= iack_next;
      dack_reg      <= dack_next;
      err_reg       <= err_next;
      irdata_reg    <= irdata_next;
      drdata_reg    <= drdata_next;
      cnt_reg       <= cnt_next;
      last_data_reg <= last_data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (ireq || dreq) state_next = grant_data ? DBUSY : IBUSY;
      end
      IBUSY, DBUSY: begin
        if (mrdy || timeout_hit) state_next = ACK;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mreq_next      = mreq_reg;
    mwe_next       = mwe_reg;
    maddr_next     = maddr_reg;
    mwdata_next    = mwdata_reg;
    mbe_next       = mbe_reg;
    iack_next      = 1'b0;
    dack_next      = 1'b0;
    err_next       = 1'b0;
    irdata_next    = irdata_reg;
    drdata_next    = drdata_reg;
    cnt_next       = cnt_reg;
    last_data_next = last_data_reg;

    if (state_reg == IDLE && (ireq || dreq)) begin
      mreq_next   = 1'b1;
      mwe_next    = grant_data & dwe;
      maddr_next  = grant_data ? daddr : iaddr;
      mwdata_next = grant_data ? dwdata : '0;
      mbe_next    = be_sel;
      cnt_next    = '0;
    end else if (busy) begin
      cnt_next = cnt_reg + CNT_W'(1);
      if (mrdy || timeout_hit) begin
        mreq_next      = 1'b0;
        cnt_next       = '0;
        last_data_next = (state_reg == DBUSY);
        iack_next      = (state_reg == IBUSY);
        dack_next      = (state_reg == DBUSY);
        err_next       = ~mrdy;
        // Read data lands only on a real completion; stores leave drdata alone.
        if (mrdy && state_reg == IBUSY) irdata_next = mrdata;
        if (mrdy && state_reg == DBUSY && !mwe_reg) drdata_next = mrdata;
      end
    end
  end

  assign mreq   = mreq_reg;
  assign mwe    = mwe_reg;
  assign maddr  = maddr_reg;
  assign mwdata = mwdata_reg;
  assign mbe    = mbe_reg;
  assign iack   = iack_reg;
  assign dack   = dack_reg;
  assign err    = err_reg;
  assign irdata = irdata_reg;
  assign drdata = drdata_reg;
  assign stall  = (ireq & ~iack_reg) | (dreq & ~dack_reg);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a FAIR=0 instance for most scenarios and a
// FAIR=1 instance for round-robin tie-breaking.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b0, mrdy = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dwdata = '0, mrdata = '0;
  logic [3:0]  dbe = '0;
  logic        iack, dack, err, mreq, mwe, stall;
  logic [31:0] irdata, drdata, maddr, mwdata;
  logic [3:0]  mbe;

  logic        f_ireq = 1'b0, f_dreq = 1'b0, f_mrdy = 1'b0;
  logic        f_iack, f_dack, f_err, f_mreq, f_mwe, f_stall;
  logic [31:0] f_irdata, f_drdata, f_maddr, f_mwdata;
  logic [3:0]  f_mbe;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15), .FAIR(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .ireq(ireq), .iaddr(iaddr), .iack(iack), .irdata(irdata),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dbe(dbe),
    .dack(dack), .drdata(drdata), .err(err),
    .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata), .mbe(mbe),
    .mrdata(mrdata), .mrdy(mrdy), .stall(stall)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15), .FAIR(1)) dut_fair (
    .clk(clk), .rst_n(rst_n),
    .ireq(f_ireq), .iaddr(iaddr), .iack(f_iack), .irdata(f_irdata),
    .dreq(f_dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dbe(dbe),
    .dack(f_dack), .drdata(f_drdata), .err(f_err),
    .mreq(f_mreq), .mwe(f_mwe), .maddr(f_maddr), .mwdata(f_mwdata), .mbe(f_mbe),
    .mrdata(mrdata), .mrdy(f_mrdy), .stall(f_stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs the FAIR=1 instance until one ack; returns {dack,iack} and retires that requester.
  task automatic fair_serve(output logic [1:0] who);
    who = 2'b00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (f_iack || f_dack) begin
        who = {f_dack, f_iack};
        if (f_iack) f_ireq = 1'b0;
        if (f_dack) f_dreq = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          hi_cnt;
    logic        got_ack;
    logic [1:0]  who;

    repeat (3) @(negedge clk);
    check("rst_mreq", mreq, 0);
    check("rst_acks", {iack, dack, err}, 0);
    check("rst_rdata", {irdata, drdata}, 0);
    check("rst_stall", stall, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: fetch with mrdy already high
    ireq = 1; iaddr = 32'h100; mrdy = 1; mrdata = 32'h0050_0093;
    @(negedge clk);
    check("t1_mreq_c1", {mreq, iack}, 2'b10);
    check("t1_port", {mwe, maddr, mwdata, mbe}, {1'b0, 32'h100, 32'h0, 4'hF});
    @(negedge clk);
    check("t1_ack_c2", {iack, dack, err, mreq}, 4'b1000);
    check("t1_irdata", irdata, 32'h0050_0093);
    check("t1_stall_ack", stall, 0);
    $display("[TB] txn fetch addr=0x100 rdata=0x%08h", irdata);
    ireq = 0; mrdy = 0;
    @(negedge clk);
    check("t1_ack_pulse", iack, 0);

    // 2: store with three wait states
    dreq = 1; dwe = 1; daddr = 32'h2000; dwdata = 32'hDEAD_BEEF; dbe = 4'b0011;
    mrdata = 32'h5555_AAAA;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t2_busy_port", {mreq, mwe, maddr, mwdata, mbe},
            {1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011});
      check("t2_busy_noack", {dack, stall}, 2'b01);
      if (k == 4) mrdy = 1;
    end
    @(negedge clk);
    check("t2_ack", {dack, iack, err, mreq}, 4'b1000);
    check("t2_drdata_kept", drdata, 32'h0);
    $display("[TB] txn store addr=0x2000 wdata=0xdeadbeef be=0011 err=%0b", err);
    dreq = 0; dwe = 0; mrdy = 0;
    @(negedge clk);
    check("t2_single_ack", dack, 0);

    // 3: simultaneous requests, FAIR=0 -> data first
    ireq = 1; iaddr = 32'h104; dreq = 1; dwe = 0; daddr = 32'h40; dbe = 4'hF;
    mrdy = 1; mrdata = 32'hAAAA_0001;
    @(negedge clk);
    check("t3_grant_data", {mreq, maddr}, {1'b1, 32'h40});
    @(negedge clk);
    check("t3_dack_first", {dack, iack}, 2'b10);
    check("t3_drdata", drdata, 32'hAAAA_0001);
    $display("[TB] txn tie load addr=0x40 rdata=0x%08h", drdata);
    dreq = 0; mrdata = 32'hAAAA_0002;
    @(negedge clk);
    check("t3_idle_gap", {mreq, iack, dack}, 3'b000);
    @(negedge clk);
    check("t3_grant_fetch", {mreq, mwe, maddr}, {1'b1, 1'b0, 32'h104});
    @(negedge clk);
    check("t3_iack", {iack, dack}, 2'b10);
    check("t3_irdata", irdata, 32'hAAAA_0002);
    $display("[TB] txn tie fetch addr=0x104 rdata=0x%08h", irdata);
    ireq = 0; mrdy = 0;
    @(negedge clk);

    // 6: back-to-back loads; requester retargets on seeing dack
    dreq = 1; dwe = 0; daddr = 32'h10; mrdy = 1; mrdata = 32'hCAFE_0010;
    @(negedge clk);
    check("t6_first_port", {mreq, maddr}, {1'b1, 32'h10});
    @(negedge clk);
    check("t6_first_ack", dack, 1);
    check("t6_first_data", drdata, 32'hCAFE_0010);
    $display("[TB] txn load addr=0x10 rdata=0x%08h", drdata);
    daddr = 32'h14; mrdata = 32'hCAFE_0014;
    @(negedge clk);
    check("t6_no_regrant", {mreq, dack}, 2'b00);
    @(negedge clk);
    check("t6_second_port", {mreq, maddr}, {1'b1, 32'h14});
    @(negedge clk);
    check("t6_second_ack", dack, 1);
    check("t6_second_data", drdata, 32'hCAFE_0014);
    $display("[TB] txn load addr=0x14 rdata=0x%08h", drdata);
    dreq = 0; mrdy = 0;
    @(negedge clk);

    // 4: timeout on a load
    dreq = 1; dwe = 0; daddr = 32'h3000; mrdata = 32'hBAD0_BAD0;
    hi_cnt = 0; got_ack = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mreq) hi_cnt++;
      if (dack) begin
        got_ack = 1;
        check("t4_err", err, 1);
        check("t4_rdata_kept", {irdata, drdata}, {32'hAAAA_0002, 32'hCAFE_0014});
        dreq = 0;
        break;
      end
    end
    check("t4_ack_seen", got_ack, 1);
    check("t4_mreq_cycles", hi_cnt, 15);
    $display("[TB] txn load addr=0x3000 timeout mreq_cycles=%0d", hi_cnt);
    @(negedge clk);
    check("t4_err_clear", {err, dack}, 2'b00);

    // 5: reset in DBUSY with a fetch pending
    dreq = 1; dwe = 0; daddr = 32'h50; ireq = 1; iaddr = 32'h200; mrdy = 0;
    @(negedge clk);
    @(negedge clk);
    check("t5_in_dbusy", {mreq, maddr}, {1'b1, 32'h50});
    #2 rst_n = 0;
    #1;
    check("t5_rst_mreq", mreq, 0);
    check("t5_rst_acks", {iack, dack, err}, 3'b000);
    @(negedge clk);
    rst_n = 1; dreq = 0; mrdy = 1; mrdata = 32'h00A0_0113;
    @(negedge clk);
    check("t5_fetch_port", {mreq, maddr}, {1'b1, 32'h200});
    @(negedge clk);
    check("t5_fetch_ack", {iack, dack, err}, 3'b100);
    check("t5_irdata", irdata, 32'h00A0_0113);
    $display("[TB] txn fetch after reset addr=0x200 rdata=0x%08h", irdata);
    ireq = 0; mrdy = 0;
    @(negedge clk);

    // 3b: FAIR=1 round-robin (last grant is fetch after reset)
    dwe = 0; daddr = 32'h60; iaddr = 32'h300; f_mrdy = 1; mrdata = 32'h1234_5678;
    f_ireq = 1; f_dreq = 1;
    fair_serve(who);
    check("f_tie1_data", who, 2'b10);
    fair_serve(who);
    check("f_tie1_fetch", who, 2'b01);
    $display("[TB] txn fair tie after fetch grant: data then fetch");
    f_dreq = 1;
    fair_serve(who);
    check("f_solo_data", who, 2'b10);
    f_ireq = 1; f_dreq = 1;
    fair_serve(who);
    check("f_tie2_fetch", who, 2'b01);
    fair_serve(who);
    check("f_tie2_data", who, 2'b10);
    $display("[TB] txn fair tie after data grant: fetch then data");
    f_mrdy = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
